// File: rtl/mario_pkg.sv
// Shared types and constants for the Mario sprite animator: FSM state encoding,
// sprite geometry and ROM frame indices.
package mario_pkg;

    typedef enum logic [2:0] {
        STAND = 3'd0,
        WALK1 = 3'd1,
        WALK2 = 3'd2,
        WALK3 = 3'd3,
        JUMP  = 3'd4
    } anim_state_t;

    localparam int unsigned SPRITE_DIM     = 16;
    localparam logic [3:0]  FRAME_STAND    = 4'd0;
    localparam logic [3:0]  FRAME_WALK1    = 4'd1;
    localparam logic [3:0]  FRAME_WALK2    = 4'd2;
    localparam logic [3:0]  FRAME_WALK3    = 4'd3;
    localparam logic [3:0]  FRAME_JUMP     = 4'd4;
    localparam logic [3:0]  LEFT_FRAME_OFS = 4'd5;

    // Right-facing ROM frame index for each animation state.
    function automatic logic [3:0] frame_base(input anim_state_t s);
        logic [3:0] f;
        case (s)
            STAND:   f = FRAME_STAND;
            WALK1:   f = FRAME_WALK1;
            WALK2:   f = FRAME_WALK2;
            WALK3:   f = FRAME_WALK3;
            JUMP:    f = FRAME_JUMP;
            default: f = FRAME_STAND;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector turning the vsync-rate frame_clk into a one-Clk frame_tick.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic frame_clk_q;

    // Previous sample of frame_clk for edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_q <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk;
        end
    end

    assign frame_tick = frame_clk & ~frame_clk_q;

endmodule

// File: rtl/mario_sprite_anim.sv
// Mario walk/jump animator and per-pixel sprite ROM addressing.
// Build option MARIO_MIRROR_EN: left-facing drawn by flipping columns instead of separate ROM frames.
module mario_sprite_anim
    import mario_pkg::*;
#(
    parameter int unsigned ANIM_DIV   = 4,
    parameter int unsigned LAND_TICKS = 8,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [9:0]        BallX,
    input  logic [9:0]        BallY,
    input  logic [9:0]        BallS,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              sprite_on,
    output logic [2:0]        anim_state,
    output logic              facing_left
);

    localparam int unsigned CNT_W = 8;

    logic              frame_tick;
    anim_state_t       state_q, state_d;
    logic [CNT_W-1:0]  anim_cnt_q, anim_cnt_d;
    logic [CNT_W-1:0]  land_cnt_q, land_cnt_d;
    logic              facing_q, facing_d;
    logic [9:0]        prev_x_q, prev_x_d;
    logic [9:0]        prev_y_q, prev_y_d;
    logic              prev_valid_q, prev_valid_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              sprite_on_q, sprite_on_d;

    logic [10:0] dx;
    logic [10:0] dy;
    logic        dx_nz;
    logic        dy_nz;
    logic        anim_wrap;
    logic        land_done;

    frame_tick_gen u_tick (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    assign dx        = {1'b0, BallX} - {1'b0, prev_x_q};
    assign dy        = {1'b0, BallY} - {1'b0, prev_y_q};
    assign dx_nz     = (dx != 11'd0);
    assign dy_nz     = (dy != 11'd0);
    assign anim_wrap = (anim_cnt_q == CNT_W'(ANIM_DIV - 1));
    assign land_done = (land_cnt_q == CNT_W'(LAND_TICKS - 1));

    // Facing, motion capture and animation FSM next state; only a tick with a valid previous position moves the FSM.
    always_comb begin
        state_d      = state_q;
        anim_cnt_d   = anim_cnt_q;
        land_cnt_d   = land_cnt_q;
        facing_d     = facing_q;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        prev_valid_d = prev_valid_q;
        if (frame_tick) begin
            prev_x_d     = BallX;
            prev_y_d     = BallY;
            prev_valid_d = 1'b1;
            if (prev_valid_q) begin
                if (dx_nz) begin
                    facing_d = dx[10];
                end else begin
                    facing_d = facing_q;
                end
                case (state_q)
                    STAND: begin
                        if (dy_nz) begin
                            state_d    = JUMP;
                            land_cnt_d = {CNT_W{1'b0}};
                        end else if (dx_nz) begin
                            state_d    = WALK1;
                            anim_cnt_d = {CNT_W{1'b0}};
                        end else begin
                            state_d = STAND;
                        end
                    end
                    WALK1, WALK2, WALK3: begin
                        if (dy_nz) begin
                            state_d    = JUMP;
                            land_cnt_d = {CNT_W{1'b0}};
                        end else if (!dx_nz) begin
                            state_d = STAND;
                        end else if (anim_wrap) begin
                            anim_cnt_d = {CNT_W{1'b0}};
                            case (state_q)
                                WALK1:   state_d = WALK2;
                                WALK2:   state_d = WALK3;
                                default: state_d = WALK1;
                            endcase
                        end else begin
                            anim_cnt_d = anim_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    JUMP: begin
                        // Apex frames report dy==0, so landing waits for a run of still ticks.
                        if (dy_nz) begin
                            land_cnt_d = {CNT_W{1'b0}};
                        end else if (land_done) begin
                            land_cnt_d = {CNT_W{1'b0}};
                            anim_cnt_d = {CNT_W{1'b0}};
                            state_d    = dx_nz ? WALK1 : STAND;
                        end else begin
                            land_cnt_d = land_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        state_d    = STAND;
                        anim_cnt_d = {CNT_W{1'b0}};
                        land_cnt_d = {CNT_W{1'b0}};
                    end
                endcase
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    logic [9:0] ox;
    logic [9:0] oy;
    logic       hit;
    logic [3:0] frame;
    logic [3:0] row;
    logic [3:0] col;

    // Pixel offset within the sprite box and the matching ROM address; uses current (pre-tick) frame and facing.
    always_comb begin
        ox  = DrawX - BallX;
        oy  = DrawY - BallY;
        hit = (ox < BallS) && (oy < BallS);
        row = oy[3:0];
`ifdef MARIO_MIRROR_EN
        frame = frame_base(state_q);
        col   = facing_q ? (4'd15 - ox[3:0]) : ox[3:0];
`else
        frame = frame_base(state_q) + (facing_q ? LEFT_FRAME_OFS : 4'd0);
        col   = ox[3:0];
`endif
        if (hit) begin
            rom_addr_d = ADDR_W'({frame, row, col});
        end else begin
            rom_addr_d = {ADDR_W{1'b0}};
        end
        sprite_on_d = hit;
    end

    // State and pixel-path registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= STAND;
            anim_cnt_q   <= {CNT_W{1'b0}};
            land_cnt_q   <= {CNT_W{1'b0}};
            facing_q     <= 1'b0;
            prev_x_q     <= 10'd0;
            prev_y_q     <= 10'd0;
            prev_valid_q <= 1'b0;
            rom_addr_q   <= {ADDR_W{1'b0}};
            sprite_on_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            anim_cnt_q   <= anim_cnt_d;
            land_cnt_q   <= land_cnt_d;
            facing_q     <= facing_d;
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            prev_valid_q <= prev_valid_d;
            rom_addr_q   <= rom_addr_d;
            sprite_on_q  <= sprite_on_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign sprite_on   = sprite_on_q;
    assign anim_state  = state_q;
    assign facing_left = facing_q;

endmodule

// File: tb/tb_mario_sprite_anim.sv
// Directed bench for mario_sprite_anim; pixel expectations flow through a scoreboard queue.
module tb_mario_sprite_anim;

    localparam logic [2:0] S_STAND = 3'd0;
    localparam logic [2:0] S_WALK1 = 3'd1;
    localparam logic [2:0] S_WALK2 = 3'd2;
    localparam logic [2:0] S_WALK3 = 3'd3;
    localparam logic [2:0] S_JUMP  = 3'd4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [9:0]  BallX, BallY, BallS, DrawX, DrawY;
    logic [11:0] rom_addr;
    logic        sprite_on;
    logic [2:0]  anim_state;
    logic        facing_left;

    typedef struct packed {
        logic        on;
        logic [11:0] addr;
    } pix_t;

    pix_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    mario_sprite_anim dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .BallX       (BallX),
        .BallY       (BallY),
        .BallS       (BallS),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rom_addr    (rom_addr),
        .sprite_on   (sprite_on),
        .anim_state  (anim_state),
        .facing_left (facing_left)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    task automatic n_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic on, input logic [11:0] addr);
        pix_t e;
        DrawX = x;
        DrawY = y;
        exp_q.push_back('{on: on, addr: addr});
        @(negedge Clk);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_on"}, {31'd0, sprite_on}, {31'd0, e.on});
            chk({tag, "_addr"}, {20'd0, rom_addr}, {20'd0, e.addr});
        end
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0;
        BallX = 10'd100; BallY = 10'd200; BallS = 10'd16;
        DrawX = 10'd0; DrawY = 10'd0;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_state", {29'd0, anim_state}, {29'd0, S_STAND});
        chk("rst_face", {31'd0, facing_left}, 32'd0);
        chk("rst_on", {31'd0, sprite_on}, 32'd0);
        chk("rst_addr", {20'd0, rom_addr}, 32'd0);
        Reset = 1'b0;

        // 1: constant position
        n_ticks(3);
        chk("t1_state", {29'd0, anim_state}, {29'd0, S_STAND});
        chk("t1_face", {31'd0, facing_left}, 32'd0);
        pix("t1_off", 10'd0, 10'd0, 1'b0, 12'h000);

        // 2: walk right and cycle frames
        BallX = BallX + 10'd2; tick();
        chk("t2_walk1", {29'd0, anim_state}, {29'd0, S_WALK1});
        for (int i = 0; i < 3; i++) begin BallX = BallX + 10'd2; tick(); end
        chk("t2_hold1", {29'd0, anim_state}, {29'd0, S_WALK1});
        BallX = BallX + 10'd2; tick();
        chk("t2_walk2", {29'd0, anim_state}, {29'd0, S_WALK2});
        for (int i = 0; i < 4; i++) begin BallX = BallX + 10'd2; tick(); end
        chk("t2_walk3", {29'd0, anim_state}, {29'd0, S_WALK3});
        for (int i = 0; i < 4; i++) begin BallX = BallX + 10'd2; tick(); end
        chk("t2_wrap", {29'd0, anim_state}, {29'd0, S_WALK1});
        chk("t2_face", {31'd0, facing_left}, 32'd0);
        pix("t2_pix", BallX + 10'd3, BallY + 10'd2, 1'b1, 12'h123);

        // 3: walk left
        BallX = BallX - 10'd2; tick();
        chk("t3_face", {31'd0, facing_left}, 32'd1);
        chk("t3_state", {29'd0, anim_state}, {29'd0, S_WALK1});
`ifdef MARIO_MIRROR_EN
        pix("t3_pix", BallX, BallY, 1'b1, 12'h10F);
`else
        pix("t3_pix", BallX, BallY, 1'b1, 12'h600);
`endif

        // 4: jump with apex plateau
        BallY = BallY - 10'd5; tick();
        chk("t4_jump", {29'd0, anim_state}, {29'd0, S_JUMP});
        BallY = BallY - 10'd5; tick();
        n_ticks(6);
        chk("t4_apex", {29'd0, anim_state}, {29'd0, S_JUMP});
        BallY = BallY + 10'd4; tick();
        n_ticks(7);
        chk("t4_hold", {29'd0, anim_state}, {29'd0, S_JUMP});
        chk("t4_face", {31'd0, facing_left}, 32'd1);
`ifdef MARIO_MIRROR_EN
        pix("t4_pix", BallX + 10'd1, BallY, 1'b1, 12'h40E);
`else
        pix("t4_pix", BallX + 10'd1, BallY, 1'b1, 12'h901);
`endif
        tick();
        chk("t4_land", {29'd0, anim_state}, {29'd0, S_STAND});

        // 5: box boundaries while standing right-facing
        BallX = BallX + 10'd2; tick();
        chk("t5_walk", {29'd0, anim_state}, {29'd0, S_WALK1});
        tick();
        chk("t5_stand", {29'd0, anim_state}, {29'd0, S_STAND});
        pix("t5_left", BallX - 10'd1, BallY, 1'b0, 12'h000);
        pix("t5_right", BallX + 10'd16, BallY, 1'b0, 12'h000);
        pix("t5_above", BallX, BallY - 10'd1, 1'b0, 12'h000);
        pix("t5_corner", BallX + 10'd15, BallY + 10'd15, 1'b1, 12'h0FF);

        // 6: reset mid-jump while facing left
        BallX = BallX - 10'd2; BallY = BallY - 10'd3; tick();
        chk("t6_jump", {29'd0, anim_state}, {29'd0, S_JUMP});
        chk("t6_face", {31'd0, facing_left}, 32'd1);
        DrawX = BallX; DrawY = BallY;
        @(negedge Clk);
        chk("t6_pre_on", {31'd0, sprite_on}, 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("t6_state", {29'd0, anim_state}, {29'd0, S_STAND});
        chk("t6_face0", {31'd0, facing_left}, 32'd0);
        chk("t6_addr", {20'd0, rom_addr}, 32'd0);
        chk("t6_on", {31'd0, sprite_on}, 32'd0);
        Reset = 1'b0;
        BallX = 10'd300; tick();
        chk("t6_capture", {29'd0, anim_state}, {29'd0, S_STAND});
        BallX = 10'd302; tick();
        chk("t6_rewalk", {29'd0, anim_state}, {29'd0, S_WALK1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
